// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared types and width defaults for the mp4 memory-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_WIDTH = 32;
  localparam int unsigned ARB_LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_e;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares the single cacheline-adaptor port between icache and
//             dcache, one whole line transaction per grant.
//  Config   : MEM_ARB_ROUND_ROBIN_EN - round-robin tie break (else dcache wins)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH = ARB_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_e            r_state;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic [ADDR_WIDTH-1:0] r_pmem_addr;
  logic [LINE_WIDTH-1:0] r_pmem_wdata;

  logic                  w_req_i;
  logic                  w_req_d;
  logic                  w_any_req;
  arb_req_e              w_tie_pick;
  arb_req_e              w_winner;
  logic                  w_done_i;
  logic                  w_done_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_req_e              r_rr_next;

  // Pointer moves away from whoever just finished, tie or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_next <= REQ_I;
    end else if (w_done_i) begin
      r_rr_next <= REQ_D;
    end else if (w_done_d) begin
      r_rr_next <= REQ_I;
    end
  end

  assign w_tie_pick = r_rr_next;
`else
  assign w_tie_pick = REQ_D;
`endif

  always_comb begin
    w_req_i   = i_read;
    w_req_d   = d_read | d_write;
    w_any_req = w_req_i | w_req_d;
    w_winner  = REQ_I;
    if (w_req_i && w_req_d) begin
      w_winner = w_tie_pick;
    end else if (w_req_d) begin
      w_winner = REQ_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_pmem_addr  <= '0;
      r_pmem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            if (w_winner == REQ_D) begin
              r_state      <= SERVE_D;
              r_pmem_addr  <= d_addr;
              // A simultaneous read+write from the dcache is treated as a writeback.
              r_pmem_read  <= ~d_write;
              r_pmem_write <= d_write;
              if (d_write) begin
                r_pmem_wdata <= d_wdata;
              end
            end else begin
              r_state      <= SERVE_I;
              r_pmem_addr  <= i_addr;
              r_pmem_read  <= 1'b1;
              r_pmem_write <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            r_state      <= IDLE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // A completion that coincides with reset is dropped rather than reported.
  assign w_done_i = (r_state == SERVE_I) & pmem_resp & ~rst;
  assign w_done_d = (r_state == SERVE_D) & pmem_resp & ~rst;

  assign i_resp  = w_done_i;
  assign d_resp  = w_done_d;
  assign i_rdata = w_done_i ? pmem_rdata : '0;
  assign d_rdata = w_done_d ? pmem_rdata : '0;

  assign pmem_read  = r_pmem_read;
  assign pmem_write = r_pmem_write;
  assign pmem_addr  = r_pmem_addr;
  assign pmem_wdata = r_pmem_wdata;

endmodule : mem_arbiter

`default_nettype wire
